// File: rtl/i2c_mem_pkg.sv
// Shared types and helpers for the I2C burst memory.
package i2c_mem_pkg;

    typedef enum logic {ST_INIT, ST_READY} mem_state_t;

    // Increment only the low pb bits of ptr; upper bits (page number) are kept.
    function automatic logic [31:0] page_inc(input logic [31:0] ptr, input int unsigned pb);
        logic [31:0] mask;
        mask = (32'd1 << pb) - 32'd1;
        return (ptr & ~mask) | ((ptr + 32'd1) & mask);
    endfunction

endpackage

// File: rtl/i2c_mem_array.sv
// Storage array: one synchronous write port and one registered read port.
module i2c_mem_array #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q, rdata_d;

    // Read data holds its last value unless a read is issued.
    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem_q[raddr];
    end

    // Storage is cleared by the top-level sweep, so it carries no reset.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    // Read register.
    always_ff @(posedge clk) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/i2c_mem_burst.sv
// I2C-slave backing memory with a burst address pointer, write protect and a
// clear-on-reset sweep.
module i2c_mem_burst
    import i2c_mem_pkg::*;
#(
    parameter int unsigned   DW       = 8,
    parameter int unsigned   AW       = 7,
    parameter int unsigned   PAGE     = 8,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic          busy,
    input  logic          start,
    input  logic [AW-1:0] addr_in,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    output logic          wr_err,
    input  logic          wp,
    input  logic          rd_req,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic [AW-1:0] ptr
);
    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned PB    = $clog2(PAGE);

    mem_state_t    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          wr_err_q, wr_err_d;
    logic          rd_valid_q, rd_valid_d;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          mem_re;

    // Sweep / request arbitration: start > write > read while ready.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        wr_err_d   = 1'b0;
        rd_valid_d = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = ptr_q;
        mem_wdata  = wr_data;
        mem_re     = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = idx_q;
                mem_wdata = INIT_VAL;
                idx_d     = idx_q + 1'b1;
                if (idx_q == AW'(DEPTH - 1)) state_d = ST_READY;
            end
            ST_READY: begin
                if (start) begin
                    ptr_d = addr_in;
                end else if (wr_valid) begin
                    // A protected beat still advances the pointer.
                    if (wp) wr_err_d = 1'b1;
                    else    mem_we   = 1'b1;
                    ptr_d = AW'(page_inc(32'(ptr_q), PB));
                end else if (rd_req) begin
                    mem_re     = 1'b1;
                    rd_valid_d = 1'b1;
                    ptr_d      = ptr_q + 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            idx_q      <= '0;
            ptr_q      <= '0;
            wr_err_q   <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            wr_err_q   <= wr_err_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    i2c_mem_array #(
        .DW (DW),
        .AW (AW)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (ptr_q),
        .rdata (rd_data)
    );

    assign busy     = (state_q == ST_INIT);
    assign wr_ready = ~busy;
    assign wr_err   = wr_err_q;
    assign rd_valid = rd_valid_q;
    assign ptr      = ptr_q;

endmodule
